// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver. Digits are scanned from a copy latched
// at each frame boundary, with per-slot anode blanking, leading-zero blanking and blink.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    DISPLAY_EN,
    input  logic                    BLINK_EN,
    input  logic                    LZ_SUPPRESS,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           idx;
    logic [BLK_W-1:0]           blink_cnt;
    logic                       blink_phase;
    logic [NUM_DIGITS-1:0][3:0] shadow_nib;
    logic [NUM_DIGITS-1:0]      shadow_dp;

    logic                       slot_end;
    logic                       frame_end;

    logic [NUM_DIGITS-1:0]      lz_mask_p0;
    logic                       supp_p0;
    logic                       lit_p0;
    logic [7:0]                 seg_p0;
    logic [NUM_DIGITS-1:0]      an_p0;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
        endcase
    endfunction

    // Bit k set when digit k and every digit above it are zero; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS-1:0][3:0] nibs);
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run        = run && (nibs[k] == 4'h0);
            lz_mask[k] = run;
        end
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Stage p0: decode the current scan position against the shadow copy
    always_comb begin
        lz_mask_p0 = lz_mask(shadow_nib);
        supp_p0    = LZ_SUPPRESS && lz_mask_p0[idx];
        lit_p0     = (cnt >= CNT_BLANK) && DISPLAY_EN && !(BLINK_EN && blink_phase);
        an_p0      = '1;
        seg_p0     = 8'hFF;
        if (lit_p0) begin
            an_p0[idx]  = 1'b0;
            seg_p0[7]   = ~shadow_dp[idx];
            seg_p0[6:0] = supp_p0 ? 7'h7F : hex_to_seg(shadow_nib[idx]);
        end
    end

    // Stage p1: scan state, frame-latched shadow and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt         <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow_nib  <= '0;
            shadow_dp   <= '0;
            frame_tick  <= 1'b0;
            an          <= '1;
            seg         <= 8'hFF;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            frame_tick <= frame_end;
            an         <= an_p0;
            seg        <= seg_p0;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            // Blink keeps counting frames even while BLINK_EN is low.
            if (frame_end) begin
                shadow_nib <= digits;
                shadow_dp  <= dp_in;
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios plus random
// stimulus, checked against a time-based behavioural model of the display.
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BLK   = 2;
    localparam int BD    = 2;
    localparam int FRAME = ND * SD;

    localparam logic [7:0] SEG_TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam logic [3:0] SCAN_AN  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] SCAN_SEG [4]  = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    localparam logic [7:0] LZ_ON    [4]  = '{8'hC0, 8'h92, 8'hFF, 8'h7F};
    localparam logic [7:0] LZ_OFF   [4]  = '{8'hC0, 8'h92, 8'hC0, 8'h40};

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        DISPLAY_EN = 1'b1;
    logic        BLINK_EN = 1'b0;
    logic        LZ_SUPPRESS = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    seven_segment_scanner #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BLK), .BLINK_DIV(BD)
    ) dut (
        .CLK(CLK), .RESET(RESET), .digits(digits), .dp_in(dp_in),
        .DISPLAY_EN(DISPLAY_EN), .BLINK_EN(BLINK_EN), .LZ_SUPPRESS(LZ_SUPPRESS),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    // Reference model: position p = clock edges since reset release, minus one.
    function automatic bit model_lit(int p, logic en, logic bl);
        bit blink_off;
        blink_off = ((p / FRAME / BD) % 2) == 1;
        return ((p % SD) >= BLK) && (en === 1'b1) && !((bl === 1'b1) && blink_off);
    endfunction

    function automatic logic [3:0] model_an(int p, logic en, logic bl);
        logic [3:0] a;
        a = 4'hF;
        if (model_lit(p, en, bl)) a[(p / SD) % ND] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] model_seg(int p, logic [15:0] sh, logic [3:0] dp,
                                             logic en, logic bl, logic lz);
        int d;
        logic [15:0] upper;
        logic [7:0] s;
        d = (p / SD) % ND;
        upper = sh >> (4 * d);
        if (!model_lit(p, en, bl)) return 8'hFF;
        s = SEG_TBL[upper[3:0]];
        if ((lz === 1'b1) && d > 0 && upper == 16'h0) s = 8'hFF;
        if (dp[d]) s = s & 8'h7F;
        return s;
    endfunction

    int          t;
    logic [15:0] m_shadow;
    logic [3:0]  m_dp;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_tick;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            t        <= 0;
            m_shadow <= '0;
            m_dp     <= '0;
            exp_seg  <= 8'hFF;
            exp_an   <= 4'hF;
            exp_tick <= 1'b0;
        end else begin
            t        <= t + 1;
            exp_tick <= (t % FRAME) == FRAME - 1;
            exp_an   <= model_an(t, DISPLAY_EN, BLINK_EN);
            exp_seg  <= model_seg(t, m_shadow, m_dp, DISPLAY_EN, BLINK_EN, LZ_SUPPRESS);
            if ((t % FRAME) == FRAME - 1) begin
                m_shadow <= digits;
                m_dp     <= dp_in;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        #1 RESET = 1'b1;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_immediate an=%h seg=%h tick=%b required an=F seg=FF tick=0", an, seg, frame_tick);
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held an=%h seg=%h tick=%b required an=F seg=FF tick=0", an, seg, frame_tick);
        end
        RESET = 1'b0;
    endtask

    task automatic test_scan_order();
        int p, d, s, last_tick, ticks;
        digits = 16'h1234; dp_in = '0; DISPLAY_EN = 1'b1; BLINK_EN = 1'b0; LZ_SUPPRESS = 1'b0;
        do_reset();
        last_tick = -1;
        ticks = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge CLK);
            p = t - 1; d = (p / SD) % ND; s = p % SD;
            vectors++;
            if (seg !== exp_seg || an !== exp_an || frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL scan_model p=%0d seg=%h an=%h tick=%b required seg=%h an=%h tick=%b",
                         p, seg, an, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if (p / FRAME == 1) begin
                vectors++;
                if (s < BLK) begin
                    if (an !== 4'hF || seg !== 8'hFF) begin
                        miscompares++;
                        $display("FAIL scan_blank p=%0d an=%h seg=%h required an=F seg=FF", p, an, seg);
                    end
                end else if (an !== SCAN_AN[d] || seg !== SCAN_SEG[d]) begin
                    miscompares++;
                    $display("FAIL scan_order p=%0d an=%h seg=%h required an=%h seg=%h",
                             p, an, seg, SCAN_AN[d], SCAN_SEG[d]);
                end
            end
            if (frame_tick === 1'b1) begin
                ticks++;
                vectors++;
                if ((last_tick < 0 ? p + 1 : p - last_tick) != FRAME) begin
                    miscompares++;
                    $display("FAIL tick_period p=%0d last=%0d required spacing %0d", p, last_tick, FRAME);
                end
                last_tick = p;
            end
        end
        vectors++;
        if (ticks != 3) begin
            miscompares++;
            $display("FAIL tick_count got=%0d required=3", ticks);
        end
    endtask

    task automatic test_leading_zero();
        int p, d, s;
        logic [7:0] want;
        digits = 16'h0050; dp_in = 4'b1000; DISPLAY_EN = 1'b1; BLINK_EN = 1'b0; LZ_SUPPRESS = 1'b1;
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge CLK);
            p = t - 1; d = (p / SD) % ND; s = p % SD;
            vectors++;
            if (seg !== exp_seg || an !== exp_an) begin
                miscompares++;
                $display("FAIL lz_model p=%0d seg=%h an=%h required seg=%h an=%h", p, seg, an, exp_seg, exp_an);
            end
            if (p / FRAME >= 1 && s >= BLK) begin
                want = (p / FRAME == 1) ? LZ_ON[d] : LZ_OFF[d];
                vectors++;
                if (seg !== want) begin
                    miscompares++;
                    $display("FAIL lz_digit p=%0d digit=%0d seg=%h required %h", p, d, seg, want);
                end
            end
            if (t == 2 * FRAME) LZ_SUPPRESS = 1'b0;
        end
    endtask

    task automatic test_tear_free();
        int p, f, s;
        logic [7:0] want;
        digits = 16'h1111; dp_in = '0; DISPLAY_EN = 1'b1; BLINK_EN = 1'b0; LZ_SUPPRESS = 1'b0;
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge CLK);
            p = t - 1; f = p / FRAME; s = p % SD;
            vectors++;
            if (seg !== exp_seg || an !== exp_an) begin
                miscompares++;
                $display("FAIL tear_model p=%0d seg=%h an=%h required seg=%h an=%h", p, seg, an, exp_seg, exp_an);
            end
            if (s >= BLK) begin
                want = (f == 0) ? 8'hC0 : (f == 1) ? 8'hF9 : 8'hA4;
                vectors++;
                if (seg !== want) begin
                    miscompares++;
                    $display("FAIL tear_frame p=%0d frame=%0d seg=%h required %h", p, f, seg, want);
                end
            end
            if (t == FRAME + 10) digits = 16'h2222;
        end
    endtask

    task automatic test_blink();
        int p, f, s, d;
        logic [3:0] want_an;
        digits = 16'($urandom); dp_in = 4'hF; DISPLAY_EN = 1'b1; BLINK_EN = 1'b1; LZ_SUPPRESS = 1'b0;
        do_reset();
        for (int c = 0; c < 7 * FRAME; c++) begin
            @(negedge CLK);
            p = t - 1; f = p / FRAME; s = p % SD; d = (p / SD) % ND;
            vectors++;
            if (seg !== exp_seg || an !== exp_an) begin
                miscompares++;
                $display("FAIL blink_model p=%0d seg=%h an=%h required seg=%h an=%h", p, seg, an, exp_seg, exp_an);
            end
            if (f == 2 || f == 3 || (f == 6 && p < 6 * FRAME + 12)) begin
                vectors++;
                if (an !== 4'hF || seg !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL blink_off p=%0d an=%h seg=%h required an=F seg=FF", p, an, seg);
                end
            end else if (s >= BLK) begin
                want_an = 4'hF;
                want_an[d] = 1'b0;
                vectors++;
                if (an !== want_an) begin
                    miscompares++;
                    $display("FAIL blink_on p=%0d an=%h required %h", p, an, want_an);
                end
            end
            if (t == 6 * FRAME + 13) begin
                vectors++;
                if (an !== 4'hD) begin
                    miscompares++;
                    $display("FAIL blink_release an=%h required D", an);
                end
            end
            if (t == 6 * FRAME + 12) BLINK_EN = 1'b0;
        end
    endtask

    task automatic test_disable();
        int p;
        digits = 16'($urandom); dp_in = 4'hF; DISPLAY_EN = 1'b1; BLINK_EN = 1'b0; LZ_SUPPRESS = 1'b0;
        do_reset();
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge CLK);
            p = t - 1;
            vectors++;
            if (seg !== exp_seg || an !== exp_an || frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL disable_model p=%0d seg=%h an=%h tick=%b required seg=%h an=%h tick=%b",
                         p, seg, an, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if (p / FRAME == 2) begin
                vectors++;
                if (an !== 4'hF || seg !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL disable_off p=%0d an=%h seg=%h required an=F seg=FF", p, an, seg);
                end
            end
            if (p % FRAME == FRAME - 1) begin
                vectors++;
                if (frame_tick !== 1'b1) begin
                    miscompares++;
                    $display("FAIL disable_tick p=%0d tick=%b required 1", p, frame_tick);
                end
            end
            if (t == 2 * FRAME) DISPLAY_EN = 1'b0;
            if (t == 3 * FRAME) DISPLAY_EN = 1'b1;
        end
    endtask

    task automatic test_reset_midscan();
        digits = 16'h9876; dp_in = '0; DISPLAY_EN = 1'b1; BLINK_EN = 1'b0; LZ_SUPPRESS = 1'b0;
        do_reset();
        repeat (FRAME) @(negedge CLK);
        vectors++;
        if (frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_tick_before tick=%b required 1", frame_tick);
        end
        RESET = 1'b1;
        #1;
        vectors++;
        if (frame_tick !== 1'b0 || an !== 4'hF || seg !== 8'hFF) begin
            miscompares++;
            $display("FAIL midreset_tick_clear tick=%b an=%h seg=%h required tick=0 an=F seg=FF", frame_tick, an, seg);
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 0; c < FRAME + 21; c++) begin
            @(negedge CLK);
            vectors++;
            if (seg !== exp_seg || an !== exp_an || frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL midreset_model t=%0d seg=%h an=%h required seg=%h an=%h", t, seg, an, exp_seg, exp_an);
            end
        end
        vectors++;
        if (an !== 4'hB || seg !== 8'h80) begin
            miscompares++;
            $display("FAIL midreset_pre an=%h seg=%h required an=B seg=80", an, seg);
        end
        RESET = 1'b1;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_abort an=%h seg=%h tick=%b required an=F seg=FF tick=0", an, seg, frame_tick);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            vectors++;
            if (c < 3 && (an !== 4'hF || seg !== 8'hFF)) begin
                miscompares++;
                $display("FAIL restart_blank cycle=%0d an=%h seg=%h required an=F seg=FF", c, an, seg);
            end else if (c == 3 && (an !== 4'hE || seg !== 8'hC0)) begin
                miscompares++;
                $display("FAIL restart_digit0 an=%h seg=%h required an=E seg=C0", an, seg);
            end
        end
    endtask

    task automatic test_random();
        digits = 16'($urandom); dp_in = 4'($urandom);
        DISPLAY_EN = 1'b1; BLINK_EN = 1'($urandom); LZ_SUPPRESS = 1'($urandom);
        do_reset();
        for (int c = 0; c < 12 * FRAME; c++) begin
            @(negedge CLK);
            vectors++;
            if (seg !== exp_seg || an !== exp_an || frame_tick !== exp_tick || $countones(~an) > 1) begin
                miscompares++;
                $display("FAIL random_model t=%0d seg=%h an=%h tick=%b required seg=%h an=%h tick=%b",
                         t, seg, an, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if ($urandom_range(3) == 0) begin
                digits = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(255));
                dp_in  = 4'($urandom);
            end
            if ($urandom_range(63) == 0) LZ_SUPPRESS = ~LZ_SUPPRESS;
            if ($urandom_range(47) == 0) DISPLAY_EN = ~DISPLAY_EN;
            if ($urandom_range(39) == 0) BLINK_EN = ~BLINK_EN;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached after %0d vectors", vectors);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_scan_order();
        test_leading_zero();
        test_tear_free();
        test_blink();
        test_disable();
        test_reset_midscan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
